// File: rtl/dif_radix2_tm_pipe.sv
// Pipelined twiddle multiplier for radix-2 DIF FFT: dout = din * W_N^k (conj W when in_inv).
// Three registered stages (fold+ROM, products, add+rescale) under a valid/ready handshake.
module dif_radix2_tm_pipe #(
  parameter int DATA_WIDTH_IN  = 10,
  parameter int DATA_WIDTH_OUT = DATA_WIDTH_IN + 1,
  parameter int COEF_WIDTH     = 10,
  parameter int LOG2_N         = 6,
  parameter int ROUND          = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_inv,
  input  logic [LOG2_N-1:0]         in_k,
  input  logic [DATA_WIDTH_IN-1:0]  din_real,
  input  logic [DATA_WIDTH_IN-1:0]  din_imag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH_OUT-1:0] dout_real,
  output logic [DATA_WIDTH_OUT-1:0] dout_imag
);
  localparam int N     = 1 << LOG2_N;
  localparam int N8    = N / 8;
  localparam int IW    = LOG2_N - 2;
  localparam int PP    = DATA_WIDTH_IN + COEF_WIDTH;
  localparam int PW    = PP + 1;
  localparam int SHIFT = COEF_WIDTH - 2;
  localparam int RND_I = (ROUND != 0) ? (1 << (COEF_WIDTH - 3)) : 0;

  // Elaboration-time table value for theta = 2*pi*idx/N, idx in 0..N/8 (all non-negative).
  function automatic logic signed [COEF_WIDTH-1:0] rom_val(input int idx, input bit use_sin);
    real theta;
    real v;
    theta = 2.0 * 3.14159265358979323846 * real'(idx) / real'(N);
    v = use_sin ? $sin(theta) : $cos(theta);
    return COEF_WIDTH'($rtoi(v * real'(1 << SHIFT) + 0.5));
  endfunction

  logic signed [COEF_WIDTH-1:0] rom_cos [N8+1];
  logic signed [COEF_WIDTH-1:0] rom_sin [N8+1];

  for (genvar gi = 0; gi <= N8; gi++) begin : g_rom
    assign rom_cos[gi] = rom_val(gi, 1'b0);
    assign rom_sin[gi] = rom_val(gi, 1'b1);
  end

  logic                             adv;
  logic [2:0]                       oct;
  logic [IW-1:0]                    r_lo;
  logic [IW-1:0]                    idx;
  logic signed [COEF_WIDTH-1:0]     c_rom, s_rom, cos_v, sin_v;
  logic signed [PW-1:0]             re_rnd, im_rnd;

  logic                             s1_valid_q, s1_valid_d;
  logic signed [DATA_WIDTH_IN-1:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic signed [COEF_WIDTH-1:0]     s1_wr_q, s1_wr_d, s1_wi_q, s1_wi_d;
  logic                             s2_valid_q, s2_valid_d;
  logic signed [PP-1:0]             s2_ac_q, s2_ac_d, s2_bd_q, s2_bd_d;
  logic signed [PP-1:0]             s2_ad_q, s2_ad_d, s2_bc_q, s2_bc_d;
  logic                             out_valid_q, out_valid_d;
  logic signed [DATA_WIDTH_OUT-1:0] dout_real_q, dout_real_d, dout_imag_q, dout_imag_d;

  always_comb begin
    adv   = ~out_valid_q | out_ready;
    oct   = in_k[LOG2_N-1 -: 3];
    r_lo  = IW'(in_k) & IW'(N8 - 1);
    idx   = oct[0] ? (IW'(N8) - r_lo) : r_lo;
    c_rom = rom_cos[idx];
    s_rom = rom_sin[idx];
    // Recover cos/sin of the full angle from the first-octant pair.
    unique case (oct)
      3'd0:    begin cos_v =  c_rom; sin_v =  s_rom; end
      3'd1:    begin cos_v =  s_rom; sin_v =  c_rom; end
      3'd2:    begin cos_v = -s_rom; sin_v =  c_rom; end
      3'd3:    begin cos_v = -c_rom; sin_v =  s_rom; end
      3'd4:    begin cos_v = -c_rom; sin_v = -s_rom; end
      3'd5:    begin cos_v = -s_rom; sin_v = -c_rom; end
      3'd6:    begin cos_v =  s_rom; sin_v = -c_rom; end
      default: begin cos_v =  c_rom; sin_v = -s_rom; end
    endcase

    re_rnd = PW'(s2_ac_q) - PW'(s2_bd_q) + PW'(RND_I);
    im_rnd = PW'(s2_ad_q) + PW'(s2_bc_q) + PW'(RND_I);

    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_wr_d     = s1_wr_q;
    s1_wi_d     = s1_wi_q;
    s2_valid_d  = s2_valid_q;
    s2_ac_d     = s2_ac_q;
    s2_bd_d     = s2_bd_q;
    s2_ad_d     = s2_ad_q;
    s2_bc_d     = s2_bc_q;
    out_valid_d = out_valid_q;
    dout_real_d = dout_real_q;
    dout_imag_d = dout_imag_q;

    if (adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d  = din_real;
        s1_b_d  = din_imag;
        s1_wr_d = cos_v;
        s1_wi_d = in_inv ? sin_v : -sin_v;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_ac_d = PP'(s1_a_q) * PP'(s1_wr_q);
        s2_bd_d = PP'(s1_b_q) * PP'(s1_wi_q);
        s2_ad_d = PP'(s1_a_q) * PP'(s1_wi_q);
        s2_bc_d = PP'(s1_b_q) * PP'(s1_wr_q);
      end
      // Empty slots leave dout at its last value.
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        dout_real_d = DATA_WIDTH_OUT'(re_rnd >>> SHIFT);
        dout_imag_d = DATA_WIDTH_OUT'(im_rnd >>> SHIFT);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_wr_q     <= '0;
      s1_wi_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_ac_q     <= '0;
      s2_bd_q     <= '0;
      s2_ad_q     <= '0;
      s2_bc_q     <= '0;
      out_valid_q <= 1'b0;
      dout_real_q <= '0;
      dout_imag_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_wr_q     <= s1_wr_d;
      s1_wi_q     <= s1_wi_d;
      s2_valid_q  <= s2_valid_d;
      s2_ac_q     <= s2_ac_d;
      s2_bd_q     <= s2_bd_d;
      s2_ad_q     <= s2_ad_d;
      s2_bc_q     <= s2_bc_d;
      out_valid_q <= out_valid_d;
      dout_real_q <= dout_real_d;
      dout_imag_q <= dout_imag_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign dout_real = dout_real_q;
  assign dout_imag = dout_imag_q;

endmodule

// File: tb/tb_dif_radix2_tm_pipe.sv
// Bench for dif_radix2_tm_pipe: directed rotations, random streams with random valid/ready,
// stall, and mid-stream reset, all scored against an unfolded complex-multiply reference.
module tb_dif_radix2_tm_pipe;
  localparam int  DWI    = 10;
  localparam int  DWO    = 11;
  localparam int  LOG2_N = 6;
  localparam int  NN     = 64;
  localparam real PI     = 3.14159265358979323846;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [LOG2_N-1:0] in_k;
  logic [DWI-1:0] din_real, din_imag;
  logic [DWO-1:0] dout_real, dout_imag;

  dif_radix2_tm_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv), .in_k(in_k),
    .din_real(din_real), .din_imag(din_imag),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout_real(dout_real), .dout_imag(dout_imag)
  );

  always #5 clk = ~clk;

  typedef struct { longint re; longint im; } cplx_t;

  int     n_chk = 0;
  int     n_pass = 0;
  cplx_t  exp_q[$];
  cplx_t  rec[128];
  int     out_cnt;
  bit     acc;
  int     cur_k, cur_a, cur_b;
  bit     cur_inv;
  int     tab_a[64], tab_b[64];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_chk++;
    if (obs !== expv) $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    else n_pass++;
  endtask

  function automatic longint rnd(input real x);
    return (x >= 0.0) ? longint'($rtoi(x + 0.5)) : -longint'($rtoi(-x + 0.5));
  endfunction

  // Direct complex multiply by the rounded ideal twiddle, then the rounded rescale by 256.
  function automatic cplx_t model(input int k, input bit inv, input longint a, input longint b);
    real    th;
    longint wr, wi;
    cplx_t  res;
    th = 2.0 * PI * real'(k) / real'(NN);
    wr = rnd(256.0 * $cos(th));
    wi = rnd(-256.0 * $sin(th));
    if (inv) wi = -wi;
    res.re = (a * wr - b * wi + 128) >>> 8;
    res.im = (a * wi + b * wr + 128) >>> 8;
    return res;
  endfunction

  task automatic drive(input int k, input bit inv, input int a, input int b);
    in_k     = LOG2_N'(k);
    in_inv   = inv;
    din_real = DWI'(a);
    din_imag = DWI'(b);
  endtask

  // One clock: score the transfers the coming edge will perform, then advance to the next negedge.
  task automatic step();
    cplx_t e;
    #1;
    acc = 1'b0;
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(model(int'(in_k), in_inv, longint'($signed(din_real)), longint'($signed(din_imag))));
      acc = 1'b1;
    end
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("dout_re", $signed(dout_real), e.re);
        chk("dout_im", $signed(dout_imag), e.im);
        if (out_cnt < 128) begin
          rec[out_cnt].re = longint'($signed(dout_real));
          rec[out_cnt].im = longint'($signed(dout_imag));
        end
        out_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_check(input string tag, input int k, input bit inv, input int a, input int b,
                            input int er, input int ei);
    int lat;
    drive(k, inv, a, b);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_re"}, $signed(dout_real), er);
    chk({tag, "_im"}, $signed(dout_imag), ei);
    step();
  endtask

  task automatic gen_beat(input int i, input bit table_mode);
    int j;
    if (table_mode) begin
      j       = i % 64;
      cur_inv = (i >= 64);
      cur_k   = cur_inv ? (64 - j) % 64 : j;
      cur_a   = tab_a[j];
      cur_b   = tab_b[j];
    end else begin
      cur_k   = $urandom_range(0, 63);
      cur_inv = $urandom_range(0, 1);
      cur_a   = int'($urandom_range(0, 1023)) - 512;
      cur_b   = int'($urandom_range(0, 1023)) - 512;
    end
  endtask

  task automatic run_stream(input string tag, input int nb, input bit table_mode);
    int bi;
    int guard;
    bi = 0;
    guard = 0;
    out_cnt = 0;
    gen_beat(0, table_mode);
    while ((bi < nb || exp_q.size() != 0) && guard < 20000) begin
      if (bi < nb) begin
        drive(cur_k, cur_inv, cur_a, cur_b);
        in_valid = ($urandom_range(0, 3) != 0);
      end else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 9) < 7);
      step();
      guard++;
      if (acc) begin
        bi++;
        gen_beat(bi, table_mode);
      end
    end
    chk({tag, "_count"}, out_cnt, nb);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int    bi;
    int    sk[8], sa[8], sb[8];
    logic [DWO-1:0] snap_re, snap_im;
    int    extra;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive(0, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout_re", dout_real, 0);
    chk("rst_dout_im", dout_imag, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    send_check("k0",      0,  1'b0,  300, -200,  300, -200);
    send_check("k16",     16, 1'b0,  100,   50,   50, -100);
    send_check("k32",     32, 1'b0,  100,   50, -100,  -50);
    send_check("k16inv",  16, 1'b1,  100,   50,  -50,  100);
    send_check("k48",     48, 1'b0,  100,   50,  -50,  100);
    send_check("k8_unit", 8,  1'b0,    1,    0,    1,   -1);
    send_check("k8_256",  8,  1'b0,  256,    0,  181, -181);
    send_check("k0_min",  0,  1'b0, -512, -512, -512, -512);
    send_check("k32_min", 32, 1'b0, -512, -512,  512,  512);

    // Every k in both directions, N-k paired with the conjugate on the same sample.
    for (int j = 0; j < 64; j++) begin
      tab_a[j] = int'($urandom_range(0, 1023)) - 512;
      tab_b[j] = int'($urandom_range(0, 1023)) - 512;
    end
    run_stream("sweep", 128, 1'b1);
    for (int j = 0; j < 64; j++) begin
      chk("pair_re", rec[64 + j].re, rec[j].re);
      chk("pair_im", rec[64 + j].im, rec[j].im);
    end

    run_stream("random", 900, 1'b0);

    // Eight back-to-back beats with a five-cycle downstream hold in the middle.
    for (int i = 0; i < 8; i++) begin
      sk[i] = $urandom_range(0, 63);
      sa[i] = int'($urandom_range(0, 1023)) - 512;
      sb[i] = int'($urandom_range(0, 1023)) - 512;
    end
    bi = 0;
    out_cnt = 0;
    snap_re = '0;
    snap_im = '0;
    for (int c = 0; c < 26; c++) begin
      in_valid = (bi < 8);
      if (bi < 8) drive(sk[bi], 1'b0, sa[bi], sb[bi]);
      out_ready = !(c >= 6 && c < 11);
      if (c >= 6 && c < 11) begin
        #1;
        chk("stall_in_ready", in_ready, 0);
        if (c == 6) begin
          snap_re = dout_real;
          snap_im = dout_imag;
        end else begin
          chk("stall_frozen_re", dout_real, snap_re);
          chk("stall_frozen_im", dout_imag, snap_im);
        end
      end
      step();
      if (acc) bi++;
    end
    chk("stall_count", out_cnt, 8);

    // Reset with three beats in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(0, 63), 1'b0, 123, -45);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_dout_re", dout_real, 0);
    chk("midrst_dout_im", dout_imag, 0);
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    send_check("post_rst", 16, 1'b0, 100, 50, 50, -100);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid) extra++;
      step();
    end
    chk("post_rst_extra", extra, 0);
    chk("sb_leftover", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
